led_scan_ctrl: RTL and testbench

Sequencer that drives the LED output decoder. It time-multiplexes NUM_POS display positions by stepping led_sel and driving per-position enables, with a blanking gap before each position to prevent ghosting. It double-buffers the 10-bit game state so the decoder only sees new state at frame boundaries, which prevents tearing. It also provides frame-synchronous blinking. It sits between game logic and the combinational LED decoder: led_sel and state_out feed the decoder, and blank gates its output.

---
 rtl/led_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - LED position scan sequencer with frame-synchronous state buffer and blink
module led_scan_ctrl #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 64,
   parameter int NUM_POS      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [9:0] state_in,
   input  logic       state_wr,
   input  logic       blink_en,
   output logic [2:0] led_sel,
   output logic [9:0] state_out,
   output logic [7:0] digit_en_n,
   output logic       blank,
   output logic       frame_start
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = $clog2(BLINK_FRAMES + 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          st_q, st_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      sel_q, sel_d;
   logic [9:0]      pend_q, pend_d;
   logic            pv_q, pv_d;
   logic [9:0]      sout_q, sout_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic            phase_q, phase_d;
   logic [7:0]      den_q, den_d;
   logic            blank_q, blank_d;
   logic            fs_q;
   logic            boundary;
   logic            lit;

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      boundary = 1'b0;
      case (st_q)
         IDLE: begin
            if (en) begin
               st_d     = SCAN;
               cnt_d    = '0;
               sel_d    = 3'd0;
               boundary = 1'b1;
            end
         end
         SCAN: begin
            if (!en) begin
               st_d  = IDLE;
               cnt_d = '0;
               sel_d = 3'd0;
            end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
               cnt_d = '0;
               if (sel_q == 3'(NUM_POS - 1)) begin
                  sel_d    = 3'd0;
                  boundary = 1'b1;
               end else begin
                  sel_d = sel_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: st_d = IDLE;
      endcase

      // Transfer uses the old pending value; a coincident write stays pending.
      pend_d = pend_q;
      pv_d   = pv_q;
      sout_d = sout_q;
      if (boundary && pv_q) begin
         sout_d = pend_q;
         pv_d   = 1'b0;
      end
      if (state_wr) begin
         pend_d = state_in;
         pv_d   = 1'b1;
      end

      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (!blink_en) begin
         fcnt_d  = '0;
         phase_d = 1'b1;
      end else if (boundary) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end

      lit = (st_d == SCAN) && (cnt_d >= CW'(BLANK_CYCLES)) && !(blink_en && !phase_d);
      den_d = 8'hFF;
      if (lit) den_d[sel_d] = 1'b0;
      blank_d = ~lit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         cnt_q   <= '0;
         sel_q   <= 3'd0;
         pend_q  <= 10'd0;
         pv_q    <= 1'b0;
         sout_q  <= 10'd0;
         fcnt_q  <= '0;
         phase_q <= 1'b1;
         den_q   <= 8'hFF;
         blank_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
         pv_q    <= pv_d;
         sout_q  <= sout_d;
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
         den_q   <= den_d;
         blank_q <= blank_d;
         fs_q    <= boundary;
      end
   end

   assign led_sel     = sel_q;
   assign state_out   = sout_q;
   assign digit_en_n  = den_q;
   assign blank       = blank_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - table-driven and directed checks for led_scan_ctrl
module tb_led_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, state_wr, blink_en;
   logic [9:0] state_in;
   logic [2:0] led_sel;
   logic [9:0] state_out;
   logic [7:0] digit_en_n;
   logic       blank, frame_start;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   led_scan_ctrl #(
      .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2), .NUM_POS(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .state_in(state_in), .state_wr(state_wr),
      .blink_en(blink_en), .led_sel(led_sel), .state_out(state_out),
      .digit_en_n(digit_en_n), .blank(blank), .frame_start(frame_start)
   );

   typedef struct {
      logic       en;
      logic       wr;
      logic       blink;
      logic [9:0] din;
      logic [2:0] sel;
      logic [9:0] sout;
      logic [7:0] den;
      logic       blank;
      logic       fs;
   } vec_t;

   vec_t tbl[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] s, input logic [9:0] so,
                          input logic [7:0] d, input logic b, input logic f);
      check({tag, ".led_sel"},     32'(led_sel),     32'(s));
      check({tag, ".state_out"},   32'(state_out),   32'(so));
      check({tag, ".digit_en_n"},  32'(digit_en_n),  32'(d));
      check({tag, ".blank"},       32'(blank),       32'(b));
      check({tag, ".frame_start"}, 32'(frame_start), 32'(f));
   endtask

   task automatic wait_fs(input logic [9:0] pre, output int n);
      n = 0;
      do begin
         step();
         n++;
         if (!frame_start) check("state_out_hold", 32'(state_out), 32'(pre));
      end while (!frame_start && n < 200);
      check("frame_start_seen", 32'(frame_start), 32'd1);
   endtask

   function automatic logic [7:0] den_of(input int sel, input int c, input bit vis);
      logic [7:0] one;
      one = 8'h01;
      if (!vis || c < 2) return 8'hFF;
      return ~(one << sel);
   endfunction

   function automatic vec_t mk(input logic e, input logic w, input logic bl, input logic [9:0] di,
                               input logic [2:0] s, input logic [9:0] so, input logic [7:0] d,
                               input logic b, input logic f);
      vec_t v;
      v.en = e; v.wr = w; v.blink = bl; v.din = di;
      v.sel = s; v.sout = so; v.den = d; v.blank = b; v.fs = f;
      return v;
   endfunction

   initial begin
      int n, j, f, c;
      bit vis;
      logic [7:0] d;

      rst = 1'b1; en = 1'b0; state_wr = 1'b0; blink_en = 1'b0; state_in = 10'd0;
      repeat (3) step();
      rst = 1'b0;
      chk_out("reset", 3'd0, 10'd0, 8'hFF, 1'b1, 1'b0);

      // Idle vectors, then one full frame plus the start of the next.
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 10'd0, 3'd0, 10'd0, 8'hFF, 1, 0));
      for (int k = 0; k <= 64; k++) begin
         j = k % 64;
         d = den_of(j / 8, j % 8, 1'b1);
         tbl.push_back(mk(1, 0, 0, 10'd0, 3'(j / 8), 10'd0, d, (d == 8'hFF), (j == 0)));
      end
      foreach (tbl[i]) begin
         en = tbl[i].en; state_wr = tbl[i].wr; blink_en = tbl[i].blink; state_in = tbl[i].din;
         step();
         chk_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].sout, tbl[i].den, tbl[i].blank, tbl[i].fs);
      end

      // Double buffer: two writes mid-frame, last one wins at the boundary.
      state_in = 10'h001; state_wr = 1'b1; step(); state_wr = 1'b0;
      check("dbuf_mid1", 32'(state_out), 32'h0);
      repeat (3) step();
      state_in = 10'h3FF; state_wr = 1'b1; step(); state_wr = 1'b0;
      check("dbuf_mid2", 32'(state_out), 32'h0);
      wait_fs(10'h000, n);
      check("dbuf_wait", 32'(n), 32'd59);
      check("dbuf_load", 32'(state_out), 32'h3FF);
      wait_fs(10'h3FF, n);
      check("frame_period", 32'(n), 32'd64);
      check("dbuf_keep", 32'(state_out), 32'h3FF);

      // Coincident write at the boundary edge.
      state_in = 10'h055; state_wr = 1'b1; step(); state_wr = 1'b0;
      repeat (62) step();
      chk_out("coinc_pre", 3'd7, 10'h3FF, 8'h7F, 1'b0, 1'b0);
      state_in = 10'h2A5; state_wr = 1'b1; step(); state_wr = 1'b0;
      chk_out("coinc_fs", 3'd0, 10'h055, 8'hFF, 1'b1, 1'b1);
      wait_fs(10'h055, n);
      check("coinc_period", 32'(n), 32'd64);
      check("coinc_next", 32'(state_out), 32'h2A5);

      // Blink: enabled just after a frame start; frames 2-3 dark.
      blink_en = 1'b1;
      for (int k = 1; k < 384; k++) begin
         step();
         f = k / 64; j = k % 64; c = j % 8;
         vis = (f < 2) || (f >= 4);
         d = den_of(j / 8, c, vis);
         chk_out($sformatf("blink_f%0d_j%0d", f, j), 3'(j / 8), 10'h2A5, d, (d == 8'hFF), (j == 0));
      end
      step();
      chk_out("blink_f6_start", 3'd0, 10'h2A5, 8'hFF, 1'b1, 1'b1);
      repeat (2) step();
      chk_out("blink_f6_dark", 3'd0, 10'h2A5, 8'hFF, 1'b1, 1'b0);
      blink_en = 1'b0; step();
      chk_out("blink_off", 3'd0, 10'h2A5, 8'hFE, 1'b0, 1'b0);
      blink_en = 1'b1;
      wait_fs(10'h2A5, n);
      repeat (2) step();
      chk_out("blink_restart_vis", 3'd0, 10'h2A5, 8'hFE, 1'b0, 1'b0);
      wait_fs(10'h2A5, n);
      repeat (2) step();
      chk_out("blink_restart_dark", 3'd0, 10'h2A5, 8'hFF, 1'b1, 1'b0);
      blink_en = 1'b0; step();
      chk_out("blink_off2", 3'd0, 10'h2A5, 8'hFE, 1'b0, 1'b0);

      // Abort at led_sel=3, cnt=5 with a pending write; then re-enable.
      wait_fs(10'h2A5, n);
      state_in = 10'h1C3; state_wr = 1'b1; step(); state_wr = 1'b0;
      repeat (28) step();
      chk_out("abort_pre", 3'd3, 10'h2A5, 8'hF7, 1'b0, 1'b0);
      en = 1'b0; step();
      chk_out("abort_idle", 3'd0, 10'h2A5, 8'hFF, 1'b1, 1'b0);
      repeat (2) step();
      chk_out("abort_idle_hold", 3'd0, 10'h2A5, 8'hFF, 1'b1, 1'b0);
      en = 1'b1; step();
      chk_out("reenable", 3'd0, 10'h1C3, 8'hFF, 1'b1, 1'b1);
      step();
      chk_out("reenable_next", 3'd0, 10'h1C3, 8'hFF, 1'b1, 1'b0);

      // Reset with pending data discards it.
      state_in = 10'h0F0; state_wr = 1'b1; step(); state_wr = 1'b0;
      rst = 1'b1; step();
      chk_out("rst_mid", 3'd0, 10'h000, 8'hFF, 1'b1, 1'b0);
      rst = 1'b0; step();
      chk_out("rst_restart", 3'd0, 10'h000, 8'hFF, 1'b1, 1'b1);
      repeat (10) step();
      chk_out("rst_scan", 3'd1, 10'h000, 8'hFD, 1'b0, 1'b0);
      wait_fs(10'h000, n);
      check("rst_pending_gone", 32'(state_out), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
